// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped serial transmitter sitting on the CPU address/data bus.
// Register window at BASE_ADDR: +0 TXDATA (push), +1 STATUS, +2 DIV (bit period = DIV+1 clocks).
// Define BUS_UART_TX_PARITY_EN to insert an even-parity bit before STOP (8E1); default is 8N1.
module bus_uart_tx #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr_bus,
  inout  wire  [7:0] bus,
  input  logic       c_ri,
  input  logic       c_ro,
  output logic       tx
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [PW:0]    CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]    CNT_FULL = (PW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef BUS_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [7:0]    offset;
  logic          in_win, sel_data, sel_stat, sel_div;
  logic          c_ri_q, c_ro_q, wr_stb, rd_rise;
  logic [7:0]    div_reg;
  logic          overflow;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          empty, full, busy;
  logic          push_req, push_ok, ovf_set, pop;
  logic [7:0]    status, rd_data;
  logic [7:0]    timer;
  logic          bit_done, load_bit, shift;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          tx_q, tx_n;
`ifdef BUS_UART_TX_PARITY_EN
  logic          parity_q;
`endif

  // Address decode uses a wrapping offset so the window may sit anywhere in the map.
  assign offset   = addr_bus - BASE_ADDR;
  assign in_win   = (offset < 8'd3);
  assign sel_data = in_win && (offset == 8'd0);
  assign sel_stat = in_win && (offset == 8'd1);
  assign sel_div  = in_win && (offset == 8'd2);

  assign wr_stb   = c_ri && !c_ri_q;
  assign rd_rise  = c_ro && !c_ro_q;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign busy     = (state != S_IDLE);

  // A push while full is still accepted when the transmitter frees a slot on the same edge.
  assign push_req = wr_stb && sel_data;
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  assign status   = {4'(count), overflow, full, empty, busy};
  assign bit_done = (timer == 8'd0);
  assign tx       = tx_q;

  // Read mux: unmapped TXDATA reads return zero.
  always_comb begin
    rd_data = 8'h00;
    if (sel_stat) begin
      rd_data = status;
    end else if (sel_div) begin
      rd_data = div_reg;
    end
  end

  assign bus = (c_ro && in_win) ? rd_data : 8'hzz;

  // Strobe history, divisor register and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_ri_q   <= 1'b0;
      c_ro_q   <= 1'b0;
      div_reg  <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      c_ri_q <= c_ri;
      c_ro_q <= c_ro;
      if (wr_stb && sel_div) begin
        div_reg <= bus;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (rd_rise && sel_stat) begin
        overflow <= 1'b0;
      end
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus;
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus the value tx takes for the next bit; tx only changes on bit boundaries.
  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    load_bit = 1'b0;
    shift    = 1'b0;
    tx_n     = tx_q;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_n  = S_START;
          pop      = 1'b1;
          load_bit = 1'b1;
          tx_n     = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_n  = S_DATA;
          load_bit = 1'b1;
          tx_n     = shreg[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          load_bit = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
            state_n = S_PARITY;
            tx_n    = parity_q;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            shift = 1'b1;
            tx_n  = shreg[1];
          end
        end
      end
`ifdef BUS_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_n  = S_STOP;
          load_bit = 1'b1;
          tx_n     = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          if (!empty) begin
            state_n  = S_START;
            pop      = 1'b1;
            load_bit = 1'b1;
            tx_n     = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bit timer, shift register and output flop; the timer reloads DIV only at bit boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= 8'd0;
      shreg   <= 8'd0;
      bit_cnt <= 3'd0;
      tx_q    <= 1'b1;
`ifdef BUS_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tx_q <= tx_n;
      if (load_bit) begin
        timer <= div_reg;
      end else if (timer != 8'd0) begin
        timer <= timer - 8'd1;
      end
      if (pop) begin
        shreg   <= mem[rd_ptr];
        bit_cnt <= 3'd0;
`ifdef BUS_UART_TX_PARITY_EN
        parity_q <= ^mem[rd_ptr];
`endif
      end else if (shift) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: doc/bus_uart_tx.md
# bus_uart_tx

Memory-mapped serial transmitter that responds to CPU accesses on the shared address/data bus, beside the RAM. The CPU writes bytes into a small FIFO through a register window; the block serialises them on `tx` as asynchronous frames at a programmable bit rate. The CPU reads status through the same window, so software can poll for space before writing.

## Interface
Parameters:
- `BASE_ADDR`, 8'hF0: bus address of register offset 0; the window spans BASE_ADDR..BASE_ADDR+2.
- `DEPTH`, 4: FIFO entries; power of two, 2..8.
- `DIV_RESET`, 8'd3: divisor register reset value.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `addr_bus`  in  8: CPU address bus.
- `bus`  inout  8: shared data bus. Driven only during a decoded read, else high-Z.
- `c_ri`  in  1: bus write strobe; the CPU writes the selected location.
- `c_ro`  in  1: bus read strobe; the selected location drives `bus`.
- `tx`  out  1: serial output, idle high.

## Operation
- Register map, by offset from BASE_ADDR:
  - 0, TXDATA: write-only; a write pushes one byte. Reads return 8'h00.
  - 1, STATUS: read-only. Bit0 busy (FSM not IDLE), bit1 empty, bit2 full, bit3 overflow (sticky), bits7:4 FIFO fill count.
  - 2, DIV: read/write; bit period = DIV+1 clk cycles.
- Addresses outside the window: `bus` stays high-Z and writes are ignored.
- Reads: `bus` is driven combinationally while `c_ro`=1 and `addr_bus` decodes; it is released in the same cycle the strobe drops.
- Writes: edge-detected. Action happens on the first rising `clk` edge where `c_ri`=1 after a sample with `c_ri`=0. A strobe held for several cycles performs exactly one write.
- Overflow: a TXDATA push while full, with no simultaneous pop, drops the byte and sets overflow. Overflow clears on the rising edge of `c_ro` at STATUS; the read itself still returns bit3=1.
- FIFO: circular, pointers wrap modulo DEPTH. Push and pop on the same edge are both honoured, including when full, so no overflow occurs. Count is unchanged in that case.
- FSM states and transitions:
  - IDLE: `tx`=1. Leaves to START when the FIFO is non-empty; pops the head into the shift register on that edge.
  - START: `tx`=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each. Then PARITY if compiled in, else STOP.
  - PARITY: one bit period, then STOP.
  - STOP: `tx`=1 for one bit period, then IDLE. The FIFO is re-checked on the same edge, giving back-to-back frames with no idle gap.
- Bit timer: loads DIV on entry to each bit and decrements to 0. A DIV write takes effect at the next bit boundary and never truncates the current bit. DIV=0 gives a 1-cycle bit.
- `tx` is driven from a register, never glitches combinationally.

## Timing
- Reset values:
  - `tx`=1, `bus` high-Z, FSM IDLE.
  - FIFO empty, count 0, overflow 0, DIV=DIV_RESET.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously), FIFO contents are discarded, and no partial frame resumes.
- Latency: a push accepted at edge N makes STATUS empty=0 after N. The FSM pops at N+1, and `tx` falls after N+1.
- Frame length: 10×(DIV+1) cycles, or 11×(DIV+1) with parity.
- STATUS reflects register state after the most recent edge; it is combinational from flops only.

## Configuration
- `BUS_UART_TX_PARITY_EN` defined: the PARITY state is inserted and sends even parity (XOR of the 8 data bits) between the data bits and STOP.
- Undefined: the PARITY state and its logic are absent, giving 8N1 frames.

## Test plan
- Reset, then read STATUS with DIV at reset value → `bus`=8'h02; read DIV → 8'h03; `tx`=1; `bus` high-Z when `c_ro`=0.
- Write 8'hA5 to TXDATA, DIV=3 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total; parity build inserts bit 0 before stop.
- Write 5 bytes back-to-back with DEPTH=4 while idle → first byte is popped at N+1, so all 5 are accepted and sent back-to-back with no idle cycles between stop and start. Then write 6 bytes → overflow=1; read STATUS returns bit3=1, and the next read returns bit3=0.
- Hold `c_ri` 3 cycles on TXDATA → count increments by exactly 1; write to BASE_ADDR+3 → no state change and `bus` never driven.
- Write DIV=0 mid-bit → current bit completes at the old length, and following bits last 1 cycle; assert reset mid-DATA → `tx`=1 immediately, STATUS reads 8'h02 after release.
